// File: rtl/bram_pixel_streamer.sv
// bram_pixel_streamer: reads a frame from BRAM once and streams it as raster valid/ready pixels
module bram_pixel_streamer #(
    parameter int IMG_W  = 300,
    parameter int IMG_H  = 300,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 24,
    parameter int RD_LAT = 1
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addra,
    input  logic [DATA_W-1:0] bram_douta,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int DEPTH = RD_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XW-1:0]       col_q, col_d;
    logic [YW-1:0]       row_q, row_d;
    logic [RD_LAT-1:0]   trk_q, trk_d;
    logic [2:0]          mk_q [RD_LAT];
    logic [2:0]          mk_d [RD_LAT];
    logic [DATA_W+2:0]   mem_q [DEPTH];
    logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                sof, eol, eof, last, issue, push, pop, fin;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        eol     = col_q == XW'(IMG_W - 1);
        eof     = eol && row_q == YW'(IMG_H - 1);
        sof     = col_q == '0 && row_q == '0;
        last    = addr_q == ADDR_W'(NPIX - 1);
        issue   = state_q == RUN && int'($countones(trk_q)) + int'(cnt_q) < DEPTH;
        push    = trk_q[RD_LAT-1];
        pop     = cnt_q != '0 && m_ready;
        fin     = state_q == DRAIN && pop && cnt_q == CW'(1) && trk_q == '0;
        // done_q blocks a start landing on the done cycle: the frame is not yet closed
        state_d = state_q == IDLE ? (start && !done_q ? RUN : IDLE)
                : state_q == RUN  ? (issue && last ? DRAIN : RUN)
                : (fin ? IDLE : DRAIN);
        addr_d  = state_q == IDLE ? '0 : issue && !last ? addr_q + 1'b1 : addr_q;
        col_d   = state_q == IDLE ? '0 : issue ? (eol ? '0 : col_q + 1'b1) : col_q;
        row_d   = state_q == IDLE ? '0 : issue && eol ? row_q + 1'b1 : row_q;
        trk_d   = (trk_q << 1) | RD_LAT'(issue);
        mk_d[0] = {sof, eol, eof};
        for (int i = 1; i < RD_LAT; i++) mk_d[i] = mk_q[i-1];
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        wr_d    = push ? nxt(wr_q) : wr_q;
        rd_d    = pop ? nxt(rd_q) : rd_q;
        done_d  = fin;
    end

    always_ff @(posedge clka) begin
        mk_q <= mk_d;
        if (rsta) begin
            state_q <= IDLE;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            trk_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            trk_q   <= trk_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clka) begin
        if (push) mem_q[wr_q] <= {bram_douta, mk_q[RD_LAT-1]};
    end

    assign busy       = state_q != IDLE;
    assign done       = done_q;
    assign bram_ena   = issue;
    assign bram_wea   = 1'b0;
    assign bram_addra = addr_q;
    assign m_valid    = cnt_q != '0;
    assign {m_data, m_sof, m_eol, m_eof} = m_valid ? mem_q[rd_q] : '0;
endmodule

// File: tb/tb_bram_pixel_streamer.sv
// tb_bram_pixel_streamer: random-data frames through a BRAM model, scoreboard on the pixel stream
module tb_bram_pixel_streamer;
    localparam int IMG_W  = 10;
    localparam int IMG_H  = 7;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 24;
    localparam int RD_LAT = 1;
    localparam int NPIX   = IMG_W * IMG_H;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic s, l, f;
    } beat_t;

    logic              clka = 1'b0, rsta = 1'b1, start = 1'b0, m_ready = 1'b0;
    logic              busy, done, bram_ena, bram_wea, m_valid, m_sof, m_eol, m_eof;
    logic [ADDR_W-1:0] bram_addra;
    logic [DATA_W-1:0] bram_douta, m_data;
    logic [DATA_W-1:0] pix [NPIX];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    beat_t             expq [$];
    beat_t             mon_b, held;
    logic              hold = 1'b0;
    int                tests = 0, fails = 0, beats = 0, dones = 0, issued = 0, rmode = 0;

    bram_pixel_streamer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clka(clka), .rsta(rsta), .start(start), .busy(busy), .done(done),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_douta(bram_douta),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
    );

    always #5 clka = ~clka;

    always @(posedge clka) begin
        if (bram_ena) rd_pipe[0] <= bram_addra < NPIX ? pix[bram_addra] : '0;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_douta = rd_pipe[RD_LAT-1];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clka);
        #1;
        m_ready = rmode == 1 ? 1'b1 : rmode == 2 ? ($urandom_range(0, 9) < 3) : 1'b0;
    end

    always @(negedge clka) begin
        mon_b = {m_data, m_sof, m_eol, m_eof};
        if (rsta) hold = 1'b0;
        else begin
            if (bram_ena) begin
                issued++;
                chk("addr_range", bram_addra < NPIX, 1);
                chk("outstanding", issued - beats <= RD_LAT + 2, 1);
            end
            if (hold) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_beat", mon_b, held);
            end
            if (m_valid && m_ready) begin
                if (expq.size() == 0) chk("unexpected_beat", mon_b, 0);
                else chk("beat", mon_b, expq.pop_front());
                beats++;
            end
            hold = m_valid && !m_ready;
            held = mon_b;
            if (done) dones++;
        end
    end

    task automatic frame(input int mode, input bit timing, input bit stall, input bit poke);
        int cyc, first;
        beat_t b;
        for (int a = 0; a < NPIX; a++) begin
            pix[a] = DATA_W'($urandom);
            b = '{d: pix[a], s: a == 0, l: (a % IMG_W) == IMG_W - 1, f: a == NPIX - 1};
            expq.push_back(b);
        end
        issued = 0;
        beats  = 0;
        dones  = 0;
        rmode  = mode;
        @(negedge clka);
        start = 1'b1;
        @(negedge clka);
        start = 1'b0;
        cyc   = 1;
        first = -1;
        while (!done && cyc < 20 * NPIX + 100) begin
            if (m_valid && first < 0) first = cyc;
            if (stall && first >= 0 && cyc == first + 50) begin
                chk("stall_issued", issued <= RD_LAT + 2, 1);
                chk("stall_beats", beats, 0);
                rmode = 1;
            end
            start = poke && first >= 0 && cyc == first + 5;
            @(negedge clka);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        if (timing) begin
            chk("first_valid_cycle", first, RD_LAT + 2);
            chk("frame_cycles", cyc, NPIX + RD_LAT + 2);
        end
        start = 1'b1;
        @(negedge clka);
        start = 1'b0;
        chk("start_at_done_ignored", busy, 0);
        @(negedge clka);
        chk("beats", beats, NPIX);
        chk("queue_empty", expq.size(), 0);
        chk("done_pulses", dones, 1);
    endtask

    initial begin
        int cyc;
        beat_t b;
        repeat (3) @(negedge clka);
        chk("reset_ctrl", {busy, done, bram_ena, bram_wea, m_valid, m_sof, m_eol, m_eof}, 0);
        chk("reset_addr", bram_addra, 0);
        chk("reset_data", m_data, 0);
        rsta = 1'b0;
        frame(1, 1'b1, 1'b0, 1'b0);
        frame(0, 1'b0, 1'b1, 1'b0);
        frame(2, 1'b0, 1'b0, 1'b0);
        for (int a = 0; a < NPIX; a++) begin
            b = '{d: pix[a], s: a == 0, l: (a % IMG_W) == IMG_W - 1, f: a == NPIX - 1};
            expq.push_back(b);
        end
        issued = 0;
        beats  = 0;
        rmode  = 1;
        @(negedge clka);
        start = 1'b1;
        @(negedge clka);
        start = 1'b0;
        cyc   = 0;
        while (beats < 10 && cyc < 1000) begin
            @(negedge clka);
            cyc++;
        end
        chk("reached_beat_10", beats >= 10, 1);
        rsta = 1'b1;
        @(negedge clka);
        chk("mid_reset_outputs", {m_valid, busy, bram_ena, done}, 0);
        rsta = 1'b0;
        expq.delete();
        frame(1, 1'b1, 1'b0, 1'b0);
        frame(2, 1'b0, 1'b0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
